// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 raster timing constants, coordinate types and helpers
// used by the sync generator and the graphics stage.
package vga_sync_gen_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  // Visible area bounds as seen by the graphics stage (x < MAX_X, y < MAX_Y)
  localparam int unsigned MAX_X = VGA_H_DISPLAY;
  localparam int unsigned MAX_Y = VGA_V_DISPLAY;

  typedef logic [CNT_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } raster_pos_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic line_tick;
    logic frame_tick;
  } sync_out_t;

  function automatic int unsigned div_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock divider producing a one-clk pixel enable every CLK_DIV clocks;
// the enable is forced low while reset is asserted.
module pixel_tick_div
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned    DIV_W = div_width(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == LAST) && !reset;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel enable, h/v counters, registered sync and
// line/frame strobes aligned with the counter outputs, plus video_on decode.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_tick,
  output logic             frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam coord_t V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam coord_t H_VIS    = CNT_W'(H_DISPLAY);
  localparam coord_t V_VIS    = CNT_W'(V_DISPLAY);
  localparam coord_t HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam sync_out_t SYNC_RST = '{hsync: ~H_POL, vsync: ~V_POL,
                                     line_tick: 1'b0, frame_tick: 1'b0};

  raster_pos_t pos_q;
  raster_pos_t pos_d;
  sync_out_t   sync_q;
  sync_out_t   sync_d;
  logic        h_wrap;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick)
  );

  // Counter advance: x every pixel enable, y on each x wrap
  always_comb begin
    pos_d  = pos_q;
    h_wrap = 1'b0;
    if (p_tick) begin
      if (pos_q.x == H_LAST) begin
        pos_d.x = '0;
        h_wrap  = 1'b1;
        pos_d.y = (pos_q.y == V_LAST) ? '0 : pos_q.y + CNT_W'(1);
      end else begin
        pos_d.x = pos_q.x + CNT_W'(1);
      end
    end
  end

  // Sync and strobes decode from the next position so they land with the counters
  always_comb begin
    sync_d            = SYNC_RST;
    sync_d.hsync      = in_window(pos_d.x, HS_START, HS_END) ? H_POL : ~H_POL;
    sync_d.vsync      = in_window(pos_d.y, VS_START, VS_END) ? V_POL : ~V_POL;
    sync_d.line_tick  = h_wrap;
    sync_d.frame_tick = h_wrap && (pos_d.y == V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= '0;
      sync_q <= SYNC_RST;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pixel_x    = pos_q.x;
  assign pixel_y    = pos_q.y;
  assign video_on   = (pos_q.x < H_VIS) && (pos_q.y < V_VIS);
  assign hsync      = sync_q.hsync;
  assign vsync      = sync_q.vsync;
  assign line_tick  = sync_q.line_tick;
  assign frame_tick = sync_q.frame_tick;

endmodule
